// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase codes and sizing helpers for the traffic light controllers.
package traffic_pkg;

    localparam logic [2:0] LIGHT_GREEN  = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b001;

    typedef enum logic [1:0] {
        PHASE_GREEN   = 2'b00,
        PHASE_YELLOW  = 2'b01,
        PHASE_ALL_RED = 2'b10
    } phase_t;

    // Phase counter width: wide enough to reach the longest programmed duration.
    function automatic int cntWidth(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_side_arbiter.sv
// Round-robin pick of the next side road to serve: first requester at/after the pointer,
// wrapping from the last way back to way 1. Way 0 (main road) never competes.
module rr_side_arbiter
    import traffic_pkg::*;
#(
    parameter  int NUM_WAYS = 4,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] i_req,
    input  logic [WAY_W-1:0]    i_ptr,
    output logic [WAY_W-1:0]    o_grant,
    output logic                o_grantValid
);

    logic w_unusedReq0;

    assign w_unusedReq0 = i_req[0];

    // Two passes: ways at/after the pointer first, then the wrapped-around remainder.
    always_comb begin
        o_grant      = '0;
        o_grantValid = 1'b0;
        for (int k = 1; k < NUM_WAYS; k++) begin
            if (!o_grantValid && (k >= int'(i_ptr)) && i_req[k]) begin
                o_grant      = WAY_W'(k);
                o_grantValid = 1'b1;
            end
        end
        for (int k = 1; k < NUM_WAYS; k++) begin
            if (!o_grantValid && i_req[k]) begin
                o_grant      = WAY_W'(k);
                o_grantValid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_way_traffic_controller.sv
// Multi-approach traffic light controller: main road green by default, side roads served
// round-robin on demand, yellow and all-red clearance, emergency-vehicle preemption.
module multi_way_traffic_controller
    import traffic_pkg::*;
#(
    parameter  int NUM_WAYS       = 4,
    parameter  int MAIN_MIN_GREEN = 30,
    parameter  int SIDE_GREEN     = 10,
    parameter  int YELLOW_CYC     = 5,
    parameter  int ALL_RED_CYC    = 1,
    localparam int WAY_W          = $clog2(NUM_WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_WAYS-1:0]   car_sense,
    input  logic                  emerg_req,
    input  logic [WAY_W-1:0]      emerg_way,
    output logic [3*NUM_WAYS-1:0] lights,
    output logic [WAY_W-1:0]      active_way,
    output logic [1:0]            phase
);

    localparam int CNT_W = cntWidth(MAIN_MIN_GREEN, SIDE_GREEN, YELLOW_CYC, ALL_RED_CYC);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] MAIN_LAST   = CNT_W'(MAIN_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] SIDE_LAST   = CNT_W'(SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALL_RED_CYC - 1);

    localparam logic [WAY_W:0]   WAY_LIMIT   = (WAY_W + 1)'(NUM_WAYS);
    localparam logic [WAY_W-1:0] LAST_WAY    = WAY_W'(NUM_WAYS - 1);
    localparam logic [WAY_W-1:0] FIRST_SIDE  = WAY_W'(1);

    localparam logic [3*NUM_WAYS-1:0] LIGHTS_RESET = {{(NUM_WAYS - 1){LIGHT_RED}}, LIGHT_GREEN};

    phase_t                r_phase;
    logic [WAY_W-1:0]      r_activeWay;
    logic [WAY_W-1:0]      r_nextWay;
    logic [WAY_W-1:0]      r_rrPtr;
    logic [CNT_W-1:0]      r_counter;
    logic [3*NUM_WAYS-1:0] r_lights;

    phase_t                w_phaseNext;
    logic [WAY_W-1:0]      w_activeNext;
    logic [WAY_W-1:0]      w_nextWayNext;
    logic [WAY_W-1:0]      w_rrNext;
    logic [CNT_W-1:0]      w_counterNext;
    logic [3*NUM_WAYS-1:0] w_lightsNext;

    logic                  w_emergValid;
    logic                  w_onMain;
    logic [WAY_W-1:0]      w_wayPending;
    logic [WAY_W-1:0]      w_rrAfter;
    logic [WAY_W-1:0]      w_grant;
    logic                  w_grantValid;

    rr_side_arbiter #(
        .NUM_WAYS (NUM_WAYS)
    ) u_arbiter (
        .i_req        (car_sense),
        .i_ptr        (r_rrPtr),
        .o_grant      (w_grant),
        .o_grantValid (w_grantValid)
    );

    assign w_emergValid = emerg_req && ({1'b0, emerg_way} < WAY_LIMIT);
    assign w_onMain     = (r_activeWay == '0);
    assign w_wayPending = w_emergValid ? emerg_way : r_nextWay;
    assign w_rrAfter    = (r_activeWay == LAST_WAY) ? FIRST_SIDE : r_activeWay + 1'b1;

    // Emergency toward another way cuts green short; toward the green way it freezes the exit.
    always_comb begin
        w_phaseNext   = r_phase;
        w_activeNext  = r_activeWay;
        w_nextWayNext = r_nextWay;
        w_rrNext      = r_rrPtr;
        case (r_phase)
            PHASE_GREEN: begin
                if (w_emergValid) begin
                    if (emerg_way != r_activeWay) begin
                        w_phaseNext   = PHASE_YELLOW;
                        w_nextWayNext = emerg_way;
                    end
                end else if (w_onMain) begin
                    if ((r_counter >= MAIN_LAST) && w_grantValid) begin
                        w_phaseNext   = PHASE_YELLOW;
                        w_nextWayNext = w_grant;
                    end
                end else if (r_counter >= SIDE_LAST) begin
                    w_phaseNext   = PHASE_YELLOW;
                    w_nextWayNext = '0;
                end
                if ((w_phaseNext == PHASE_YELLOW) && !w_onMain) begin
                    w_rrNext = w_rrAfter;
                end
            end
            PHASE_YELLOW: begin
                w_nextWayNext = w_wayPending;
                if (r_counter >= YELLOW_LAST) begin
                    w_phaseNext = PHASE_ALL_RED;
                end
            end
            PHASE_ALL_RED: begin
                w_nextWayNext = w_wayPending;
                if (r_counter >= ALLRED_LAST) begin
                    w_phaseNext  = PHASE_GREEN;
                    w_activeNext = w_wayPending;
                end
            end
            default: begin
                w_phaseNext  = PHASE_GREEN;
                w_activeNext = '0;
            end
        endcase
    end

    always_comb begin
        w_counterNext = r_counter;
        if (w_phaseNext != r_phase) begin
            w_counterNext = '0;
        end else if (r_counter != CNT_MAX) begin
            w_counterNext = r_counter + 1'b1;
        end
    end

    // Lamps are encoded from the next state so they change on the same edge as the phase.
    always_comb begin
        w_lightsNext = {NUM_WAYS{LIGHT_RED}};
        for (int k = 0; k < NUM_WAYS; k++) begin
            if (w_activeNext == WAY_W'(k)) begin
                case (w_phaseNext)
                    PHASE_GREEN:  w_lightsNext[3*k +: 3] = LIGHT_GREEN;
                    PHASE_YELLOW: w_lightsNext[3*k +: 3] = LIGHT_YELLOW;
                    default:      w_lightsNext[3*k +: 3] = LIGHT_RED;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= PHASE_GREEN;
            r_activeWay <= '0;
            r_nextWay   <= '0;
            r_rrPtr     <= FIRST_SIDE;
            r_counter   <= '0;
            r_lights    <= LIGHTS_RESET;
        end else begin
            r_phase     <= w_phaseNext;
            r_activeWay <= w_activeNext;
            r_nextWay   <= w_nextWayNext;
            r_rrPtr     <= w_rrNext;
            r_counter   <= w_counterNext;
            r_lights    <= w_lightsNext;
        end
    end

    assign lights     = r_lights;
    assign active_way = r_activeWay;
    assign phase      = r_phase;

endmodule

// File: tb/tb_multi_way_traffic_controller.sv
// Directed-vector bench for the traffic controller: a 4-way instance driven from a table of
// phase segments, and a 2-way instance exercised with a short hand-written sequence.
module tb_multi_way_traffic_controller;

    localparam logic [1:0] PG = 2'b00;
    localparam logic [1:0] PY = 2'b01;
    localparam logic [1:0] PR = 2'b10;

    localparam logic [11:0] ALL_RED4 = 12'h249;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  carSense;
    logic        emergReq;
    logic [1:0]  emergWay;
    logic [11:0] lights;
    logic [1:0]  activeWay;
    logic [1:0]  phase;

    logic        rst2;
    logic [1:0]  carSense2;
    logic        emergReq2;
    logic        emergWay2;
    logic [5:0]  lights2;
    logic        activeWay2;
    logic [1:0]  phase2;

    int compared   = 0;
    int mismatched = 0;

    logic [11:0] greenOf  [4] = '{12'h24C, 12'h261, 12'h309, 12'h849};
    logic [11:0] yellowOf [4] = '{12'h24A, 12'h251, 12'h289, 12'h449};

    typedef struct {
        logic        rst;
        logic [3:0]  cars;
        logic        emReq;
        logic [1:0]  emWay;
        int          n;
        logic [11:0] expLights;
        logic [1:0]  expPhase;
        logic [1:0]  expActive;
    } vec_t;

    vec_t vecs[$];

    multi_way_traffic_controller dut (
        .clk        (clk),
        .rst        (rst),
        .car_sense  (carSense),
        .emerg_req  (emergReq),
        .emerg_way  (emergWay),
        .lights     (lights),
        .active_way (activeWay),
        .phase      (phase)
    );

    multi_way_traffic_controller #(
        .NUM_WAYS (2)
    ) dut2 (
        .clk        (clk),
        .rst        (rst2),
        .car_sense  (carSense2),
        .emerg_req  (emergReq2),
        .emerg_way  (emergWay2),
        .lights     (lights2),
        .active_way (activeWay2),
        .phase      (phase2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string what, input int idx, input int cyc,
                               input logic [11:0] act, input logic [11:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s vec%0d cycle%0d: got %h, expected %h", what, idx, cyc, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic [3:0] cars, input logic emReq,
                          input logic [1:0] emWay, input int n, input logic [11:0] expLights,
                          input logic [1:0] expPhase, input logic [1:0] expActive);
        vec_t v;
        v.rst       = r;
        v.cars      = cars;
        v.emReq     = emReq;
        v.emWay     = emWay;
        v.n         = n;
        v.expLights = expLights;
        v.expPhase  = expPhase;
        v.expActive = expActive;
        vecs.push_back(v);
    endtask

    // Main green for mainTicks, clearance, then the given side way's full 10-cycle green.
    task automatic addMainToSide(input logic [3:0] cars, input int way, input int mainTicks);
        addVec(1'b0, cars, 1'b0, 2'd0, mainTicks, greenOf[0], PG, 2'd0);
        addVec(1'b0, cars, 1'b0, 2'd0, 5, yellowOf[0], PY, 2'd0);
        addVec(1'b0, cars, 1'b0, 2'd0, 1, ALL_RED4, PR, 2'd0);
        addVec(1'b0, cars, 1'b0, 2'd0, 10, greenOf[way], PG, 2'(way));
    endtask

    task automatic addSideToMain(input logic [3:0] cars, input int way);
        addVec(1'b0, cars, 1'b0, 2'd0, 5, yellowOf[way], PY, 2'(way));
        addVec(1'b0, cars, 1'b0, 2'd0, 1, ALL_RED4, PR, 2'(way));
    endtask

    task automatic buildTable();
        // reset state, idle main green, emergency hold on the green main road
        addVec(1'b1, 4'b0000, 1'b0, 2'd0, 3, greenOf[0], PG, 2'd0);
        addVec(1'b0, 4'b0000, 1'b0, 2'd0, 100, greenOf[0], PG, 2'd0);
        addVec(1'b0, 4'b1110, 1'b1, 2'd0, 10, greenOf[0], PG, 2'd0);
        addVec(1'b0, 4'b1110, 1'b0, 2'd0, 5, yellowOf[0], PY, 2'd0);
        addVec(1'b0, 4'b1110, 1'b0, 2'd0, 1, ALL_RED4, PR, 2'd0);
        addVec(1'b0, 4'b0000, 1'b0, 2'd0, 2, greenOf[1], PG, 2'd1);
        // single side request from cycle 5; car leaves during side green
        addVec(1'b1, 4'b0000, 1'b0, 2'd0, 1, greenOf[0], PG, 2'd0);
        addVec(1'b0, 4'b0000, 1'b0, 2'd0, 5, greenOf[0], PG, 2'd0);
        addVec(1'b0, 4'b0010, 1'b0, 2'd0, 24, greenOf[0], PG, 2'd0);
        addVec(1'b0, 4'b0010, 1'b0, 2'd0, 5, yellowOf[0], PY, 2'd0);
        addVec(1'b0, 4'b0010, 1'b0, 2'd0, 1, ALL_RED4, PR, 2'd0);
        addVec(1'b0, 4'b0000, 1'b0, 2'd0, 10, greenOf[1], PG, 2'd1);
        addSideToMain(4'b0000, 1);
        addVec(1'b0, 4'b0000, 1'b0, 2'd0, 3, greenOf[0], PG, 2'd0);
        // round-robin order 1,2,3,1 under continuous demand
        addVec(1'b1, 4'b0000, 1'b0, 2'd0, 1, greenOf[0], PG, 2'd0);
        addMainToSide(4'b1110, 1, 29);
        addSideToMain(4'b1110, 1);
        addMainToSide(4'b1110, 2, 30);
        addSideToMain(4'b1110, 2);
        addMainToSide(4'b1110, 3, 30);
        addSideToMain(4'b1110, 3);
        addMainToSide(4'b1110, 1, 30);
        // emergency preemption of main green at count 3, held 40 cycles, released
        addVec(1'b1, 4'b0000, 1'b0, 2'd0, 1, greenOf[0], PG, 2'd0);
        addVec(1'b0, 4'b0000, 1'b0, 2'd0, 3, greenOf[0], PG, 2'd0);
        addVec(1'b0, 4'b0000, 1'b1, 2'd2, 5, yellowOf[0], PY, 2'd0);
        addVec(1'b0, 4'b0000, 1'b1, 2'd2, 1, ALL_RED4, PR, 2'd0);
        addVec(1'b0, 4'b0000, 1'b1, 2'd2, 40, greenOf[2], PG, 2'd2);
        addSideToMain(4'b0000, 2);
        addVec(1'b0, 4'b0000, 1'b0, 2'd0, 3, greenOf[0], PG, 2'd0);
        // emergency arriving mid-yellow redirects the pending way
        addVec(1'b1, 4'b0000, 1'b0, 2'd0, 1, greenOf[0], PG, 2'd0);
        addVec(1'b0, 4'b0010, 1'b0, 2'd0, 29, greenOf[0], PG, 2'd0);
        addVec(1'b0, 4'b0010, 1'b0, 2'd0, 2, yellowOf[0], PY, 2'd0);
        addVec(1'b0, 4'b0000, 1'b1, 2'd3, 3, yellowOf[0], PY, 2'd0);
        addVec(1'b0, 4'b0000, 1'b1, 2'd3, 1, ALL_RED4, PR, 2'd0);
        addVec(1'b0, 4'b0000, 1'b0, 2'd0, 2, greenOf[3], PG, 2'd3);
        // reset during side yellow: restarts counter and round-robin pointer
        addVec(1'b1, 4'b0000, 1'b0, 2'd0, 1, greenOf[0], PG, 2'd0);
        addMainToSide(4'b1110, 1, 29);
        addVec(1'b0, 4'b1110, 1'b0, 2'd0, 2, yellowOf[1], PY, 2'd1);
        addVec(1'b1, 4'b1110, 1'b0, 2'd0, 1, greenOf[0], PG, 2'd0);
        addMainToSide(4'b1110, 1, 29);
        addSideToMain(4'b1110, 1);
        addVec(1'b0, 4'b1110, 1'b0, 2'd0, 3, greenOf[0], PG, 2'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        carSense = v.cars;
        emergReq = v.emReq;
        emergWay = v.emWay;
    endtask

    task automatic run2(input string what, input logic r, input logic [1:0] cars, input int n,
                        input logic [5:0] expLights, input logic [1:0] expPhase,
                        input logic expActive);
        rst2      = r;
        carSense2 = cars;
        for (int c = 0; c < n; c++) begin
            tick();
            checkOutput({what, "_lights"}, 0, c, {6'd0, lights2}, {6'd0, expLights});
            checkOutput({what, "_phase"}, 0, c, {10'd0, phase2}, {10'd0, expPhase});
            checkOutput({what, "_active"}, 0, c, {11'd0, activeWay2}, {11'd0, expActive});
        end
    endtask

    initial begin
        rst       = 1'b1;
        carSense  = '0;
        emergReq  = 1'b0;
        emergWay  = '0;
        rst2      = 1'b1;
        carSense2 = '0;
        emergReq2 = 1'b0;
        emergWay2 = 1'b0;

        buildTable();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            for (int c = 0; c < vecs[i].n; c++) begin
                tick();
                checkOutput("lights", i, c, lights, vecs[i].expLights);
                checkOutput("phase", i, c, {10'd0, phase}, {10'd0, vecs[i].expPhase});
                checkOutput("active", i, c, {10'd0, activeWay}, {10'd0, vecs[i].expActive});
            end
        end

        // two-way instance: short pulse before min green ignored, held demand served
        run2("w2_reset", 1'b1, 2'b00, 1, 6'h0C, PG, 1'b0);
        run2("w2_idle", 1'b0, 2'b00, 10, 6'h0C, PG, 1'b0);
        run2("w2_pulse", 1'b0, 2'b10, 1, 6'h0C, PG, 1'b0);
        run2("w2_ignored", 1'b0, 2'b00, 30, 6'h0C, PG, 1'b0);
        run2("w2_reset", 1'b1, 2'b00, 1, 6'h0C, PG, 1'b0);
        run2("w2_wait", 1'b0, 2'b00, 20, 6'h0C, PG, 1'b0);
        run2("w2_held", 1'b0, 2'b10, 9, 6'h0C, PG, 1'b0);
        run2("w2_y0", 1'b0, 2'b10, 5, 6'h0A, PY, 1'b0);
        run2("w2_ar0", 1'b0, 2'b10, 1, 6'h09, PR, 1'b0);
        run2("w2_g1", 1'b0, 2'b00, 10, 6'h21, PG, 1'b1);
        run2("w2_y1", 1'b0, 2'b00, 5, 6'h11, PY, 1'b1);
        run2("w2_ar1", 1'b0, 2'b00, 1, 6'h09, PR, 1'b1);
        run2("w2_back", 1'b0, 2'b00, 2, 6'h0C, PG, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
